// File: rtl/stream_pkg.sv
// ----------------------------------------------------------------------------
// stream_pkg
// Shared types and helpers for the stream width-conversion blocks.
//   state_t     : downsizer control state (IDLE / SEND).
//   clog2_min1  : lane-index width for a given lane count, never below 1 so
//                 that a two-lane (or degenerate) design still gets a usable
//                 index vector.
// ----------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keep_lane_select.sv
// ----------------------------------------------------------------------------
// keep_lane_select
// Purely combinational inspection of a per-lane keep mask.
// Ports:
//   i_mask : keep mask, bit k qualifies lane k.
//   o_idx  : index of the lowest set bit (0 when the mask is empty).
//   o_any  : mask has at least one bit set.
//   o_one  : mask has exactly one bit set.
// ----------------------------------------------------------------------------
module keep_lane_select
    import stream_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_one
);

    // Scan from the top down so the last match written is the lowest bit.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit mask.
    assign o_any = |i_mask;
    assign o_one = o_any && ((i_mask & (i_mask - N'(1))) == '0);

endmodule

// File: rtl/stream_downsizer.sv
// ----------------------------------------------------------------------------
// stream_downsizer
// AXI-Stream width downconverter: takes one wide beat of T_DATA_RATIO lanes
// plus a per-lane keep mask and emits the kept lanes one per narrow beat,
// lowest lane first. Lanes with keep=0 produce no narrow beat; a wide beat
// with an all-zero keep is accepted and discarded.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset.
//   s_data_i    : wide data, lane k at [k*T_DATA_WIDTH +: T_DATA_WIDTH].
//   s_keep_i    : per-lane keep.
//   s_last_i    : wide beat ends the packet.
//   s_valid_i / s_ready_o : wide-side handshake.
//   m_data_o    : narrow data.
//   m_last_o    : final narrow beat of the packet.
//   m_valid_o / m_ready_i : narrow-side handshake.
// ----------------------------------------------------------------------------
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
    input  logic [T_DATA_RATIO-1:0]              s_keep_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    output logic [T_DATA_WIDTH-1:0]              m_data_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);

    localparam int IDX_W = clog2_min1(T_DATA_RATIO);
    localparam int WIDE_W = T_DATA_WIDTH * T_DATA_RATIO;

    state_t                  r_state;
    logic [WIDE_W-1:0]       r_data;
    logic [T_DATA_RATIO-1:0] r_rem;
    logic                    r_last;

    state_t                  w_state_nxt;
    logic [WIDE_W-1:0]       w_data_nxt;
    logic [T_DATA_RATIO-1:0] w_rem_nxt;
    logic                    w_last_nxt;
    logic                    w_load;

    logic [IDX_W-1:0]        w_sel;
    logic                    w_any;
    logic                    w_one;
    logic [T_DATA_RATIO-1:0] w_sel_onehot;
    logic                    w_keep_any;
    logic [T_DATA_WIDTH-1:0] w_lanes [T_DATA_RATIO];

    keep_lane_select #(
        .N     (T_DATA_RATIO),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_mask (r_rem),
        .o_idx  (w_sel),
        .o_any  (w_any),
        .o_one  (w_one)
    );

    for (genvar g = 0; g < T_DATA_RATIO; g++) begin : g_lane
        assign w_lanes[g] = r_data[g*T_DATA_WIDTH +: T_DATA_WIDTH];
    end

    assign w_sel_onehot = T_DATA_RATIO'(1) << w_sel;
    assign w_keep_any   = |s_keep_i;

    // In SEND, w_one marks the final kept lane of the held beat. Ready is
    // combinational from m_ready_i so the next wide beat can be loaded in the
    // same cycle the final lane leaves, with no bubble.
    assign m_valid_o = (r_state == SEND);
    assign m_last_o  = (r_state == SEND) && r_last && w_one;
    assign m_data_o  = (r_state == SEND) ? w_lanes[w_sel] : '0;
    assign s_ready_o = (r_state == IDLE) || (m_ready_i && w_one);

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_last_nxt  = r_last;
        w_load      = 1'b0;

        case (r_state)
            IDLE: begin
                // Zero-keep beats are consumed here without leaving IDLE.
                if (s_valid_i && w_keep_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (m_ready_i) begin
                    w_rem_nxt = r_rem & ~w_sel_onehot;
                    if (w_one) begin
                        if (s_valid_i && w_keep_any) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_data_nxt = s_data_i;
            w_rem_nxt  = s_keep_i;
            w_last_nxt = s_last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rem   <= w_rem_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Unused in the datapath: o_any is implied by state == SEND.
    logic w_unused;
    assign w_unused = w_any;

endmodule

// File: tb/tb_stream_downsizer.sv
module tb_stream_downsizer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two-lane instance
    logic [15:0] s2_data = '0;
    logic [1:0]  s2_keep = '0;
    logic        s2_last = 1'b0, s2_valid = 1'b0, s2_ready;
    logic [7:0]  m2_data;
    logic        m2_last, m2_valid, m2_ready = 1'b0;

    // Four-lane instance
    logic [31:0] s4_data = '0;
    logic [3:0]  s4_keep = '0;
    logic        s4_last = 1'b0, s4_valid = 1'b0, s4_ready;
    logic [7:0]  m4_data;
    logic        m4_last, m4_valid, m4_ready = 1'b0;

    stream_downsizer #(.T_DATA_WIDTH(8), .T_DATA_RATIO(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s2_data), .s_keep_i(s2_keep), .s_last_i(s2_last),
        .s_valid_i(s2_valid), .s_ready_o(s2_ready),
        .m_data_o(m2_data), .m_last_o(m2_last), .m_valid_o(m2_valid),
        .m_ready_i(m2_ready)
    );

    stream_downsizer #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s4_data), .s_keep_i(s4_keep), .s_last_i(s4_last),
        .s_valid_i(s4_valid), .s_ready_o(s4_ready),
        .m_data_o(m4_data), .m_last_o(m4_last), .m_valid_o(m4_valid),
        .m_ready_i(m4_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected narrow stream for the four-lane random run
    typedef struct {
        logic [7:0] d;
        logic       l;
    } nbeat_t;
    nbeat_t q4[$];

    task automatic push_wide(input logic [31:0] d, input logic [3:0] k, input logic l);
        int hi;
        nbeat_t b;
        hi = -1;
        for (int i = 0; i < 4; i++) if (k[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                b.d = d[i*8 +: 8];
                b.l = l && (i == hi);
                q4.push_back(b);
            end
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        int          n;
        logic [31:0] exp;   // expected lanes in emission order, first at [7:0]
    } vec_t;
    vec_t vecs[6];

    // Loads a beat on u2 with the given m_ready and returns at the negedge
    // of the first SEND cycle (inputs not yet sampled for that cycle).
    task automatic load2(input logic [15:0] d, input logic [1:0] k, input logic l, input logic rdy);
        @(negedge clk);
        s2_data = d; s2_keep = k; s2_last = l; s2_valid = 1'b1; m2_ready = rdy;
        @(negedge clk);
        s2_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] xv;
        int got;
        logic prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        logic s4_hold;
        int guard;
        nbeat_t b;

        vecs[0] = '{32'h44332211, 4'b1010, 1'b1, 2, 32'h00004422};
        vecs[1] = '{32'h44332211, 4'b1111, 1'b0, 4, 32'h44332211};
        vecs[2] = '{32'hDDCCBBAA, 4'b0001, 1'b1, 1, 32'h000000AA};
        vecs[3] = '{32'hDDCCBBAA, 4'b1000, 1'b1, 1, 32'h000000DD};
        vecs[4] = '{32'h87654321, 4'b0110, 1'b1, 2, 32'h00006543};
        vecs[5] = '{32'h87654321, 4'b0000, 1'b1, 0, 32'h00000000};

        // Reset state
        #12;
        chk("rst_m_valid", {31'd0, m2_valid}, 32'd0);
        chk("rst_m_last", {31'd0, m2_last}, 32'd0);
        chk("rst_m_data", {24'd0, m2_data}, 32'd0);
        chk("rst_s_ready", {31'd0, s2_ready}, 32'd1);
        chk("rst_s_ready4", {31'd0, s4_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-lane beat
        load2(16'hBBAA, 2'b11, 1'b1, 1'b1);
        #1;
        chk("bb_v0", {31'd0, m2_valid}, 32'd1);
        chk("bb_d0", {24'd0, m2_data}, 32'hAA);
        chk("bb_l0", {31'd0, m2_last}, 32'd0);
        chk("bb_r0", {31'd0, s2_ready}, 32'd0);
        @(negedge clk); #1;
        chk("bb_d1", {24'd0, m2_data}, 32'hBB);
        chk("bb_l1", {31'd0, m2_last}, 32'd1);
        chk("bb_r1", {31'd0, s2_ready}, 32'd1);
        @(negedge clk); #1;
        chk("bb_idle", {31'd0, m2_valid}, 32'd0);

        // Zero-keep beat in IDLE is swallowed
        @(negedge clk);
        s2_data = 16'h7777; s2_keep = 2'b00; s2_last = 1'b1; s2_valid = 1'b1;
        #1;
        chk("k0_ready", {31'd0, s2_ready}, 32'd1);
        @(negedge clk);
        s2_valid = 1'b0;
        #1;
        chk("k0_novalid", {31'd0, m2_valid}, 32'd0);
        chk("k0_ready2", {31'd0, s2_ready}, 32'd1);

        // Back-to-back beats, no bubble
        @(negedge clk);
        s2_data = 16'h2211; s2_keep = 2'b11; s2_last = 1'b0; s2_valid = 1'b1; m2_ready = 1'b1;
        @(negedge clk);
        s2_data = 16'h4433; s2_last = 1'b1;
        #1;
        chk("b2b_d0", {24'd0, m2_data}, 32'h11);
        chk("b2b_r0", {31'd0, s2_ready}, 32'd0);
        @(negedge clk); #1;
        chk("b2b_d1", {24'd0, m2_data}, 32'h22);
        chk("b2b_r1", {31'd0, s2_ready}, 32'd1);
        chk("b2b_l1", {31'd0, m2_last}, 32'd0);
        @(negedge clk);
        s2_valid = 1'b0;
        #1;
        chk("b2b_v2", {31'd0, m2_valid}, 32'd1);
        chk("b2b_d2", {24'd0, m2_data}, 32'h33);
        @(negedge clk); #1;
        chk("b2b_d3", {24'd0, m2_data}, 32'h44);
        chk("b2b_l3", {31'd0, m2_last}, 32'd1);
        @(negedge clk); #1;
        chk("b2b_end", {31'd0, m2_valid}, 32'd0);

        // Backpressure hold
        load2(16'hBBAA, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_v", {31'd0, m2_valid}, 32'd1);
            chk("bp_d", {24'd0, m2_data}, 32'hAA);
            chk("bp_r", {31'd0, s2_ready}, 32'd0);
            @(negedge clk);
        end
        m2_ready = 1'b1;
        #1;
        chk("bp_rel_d0", {24'd0, m2_data}, 32'hAA);
        @(negedge clk); #1;
        chk("bp_rel_d1", {24'd0, m2_data}, 32'hBB);
        chk("bp_rel_l1", {31'd0, m2_last}, 32'd1);
        @(negedge clk); #1;
        chk("bp_end", {31'd0, m2_valid}, 32'd0);

        // Reset in the middle of a beat
        load2(16'hBBAA, 2'b11, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", {31'd0, m2_valid}, 32'd0);
        chk("mr_ready", {31'd0, s2_ready}, 32'd1);
        chk("mr_data", {24'd0, m2_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load2(16'hDDCC, 2'b10, 1'b1, 1'b1);
        #1;
        chk("mr_new_d", {24'd0, m2_data}, 32'hDD);
        chk("mr_new_l", {31'd0, m2_last}, 32'd1);
        @(negedge clk); #1;
        chk("mr_new_end", {31'd0, m2_valid}, 32'd0);

        // Table-driven four-lane vectors
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            s4_data = vecs[v].data; s4_keep = vecs[v].keep; s4_last = vecs[v].last;
            s4_valid = 1'b1; m4_ready = 1'b1;
            #1;
            chk("tv_ready", {31'd0, s4_ready}, 32'd1);
            got = 0;
            xv = vecs[v].exp;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                s4_valid = 1'b0;
                #1;
                if (c == 0) chk("tv_latency", {31'd0, m4_valid}, {31'd0, vecs[v].n != 0});
                if (m4_valid) begin
                    if (got < vecs[v].n) begin
                        chk("tv_data", {24'd0, m4_data}, {24'd0, xv[got*8 +: 8]});
                        chk("tv_last", {31'd0, m4_last}, {31'd0, vecs[v].last && (got == vecs[v].n - 1)});
                    end
                    got++;
                end
            end
            chk("tv_count", got, vecs[v].n);
        end

        // Randomized run against the lane-queue model
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; s4_hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!s4_hold) begin
                s4_valid = ($urandom_range(0, 3) != 0);
                s4_data  = $urandom;
                s4_keep  = 4'($urandom_range(0, 15));
                s4_last  = 1'($urandom_range(0, 1));
            end
            m4_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                chk("rnd_hold_v", {31'd0, m4_valid}, 32'd1);
                chk("rnd_hold_d", {24'd0, m4_data}, {24'd0, prev_data});
                chk("rnd_hold_l", {31'd0, m4_last}, {31'd0, prev_last});
            end
            if (m4_valid && m4_ready) begin
                if (q4.size() == 0) begin
                    chk("rnd_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = q4.pop_front();
                    chk("rnd_data", {24'd0, m4_data}, {24'd0, b.d});
                    chk("rnd_last", {31'd0, m4_last}, {31'd0, b.l});
                end
            end
            if (s4_valid && s4_ready) push_wide(s4_data, s4_keep, s4_last);
            s4_hold    = s4_valid && !s4_ready;
            prev_stall = m4_valid && !m4_ready;
            prev_data  = m4_data;
            prev_last  = m4_last;
        end

        // Drain
        guard = 0;
        while ((q4.size() != 0 || s4_hold || m4_valid) && guard < 200) begin
            @(negedge clk);
            if (!s4_hold) s4_valid = 1'b0;
            m4_ready = 1'b1;
            #1;
            if (m4_valid) begin
                if (q4.size() == 0) begin
                    chk("drain_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = q4.pop_front();
                    chk("drain_data", {24'd0, m4_data}, {24'd0, b.d});
                    chk("drain_last", {31'd0, m4_last}, {31'd0, b.l});
                end
            end
            if (s4_valid && s4_ready) push_wide(s4_data, s4_keep, s4_last);
            s4_hold = s4_valid && !s4_ready;
            guard++;
        end
        chk("drain_timeout", {31'd0, guard >= 200}, 32'd0);
        chk("drain_queue_empty", q4.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
